// File: rtl/tm_run_controller.sv
// Run sequencer for the tape-based Turing machine: load, paced run, halt/timeout, scroll-out.
// Optional SINGLE_STEP_EN: in RUN each Next press issues one step and Done aborts to SHOW.
module tm_run_controller #(
    parameter int unsigned DATA_W    = 7,
    parameter int unsigned TAPE_LEN  = 128,
    parameter int unsigned STEP_DIV  = 4,
    parameter int unsigned MAX_STEPS = 4096,
    localparam int unsigned ADDR_W   = $clog2(TAPE_LEN)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              next_in,
    input  logic              done_in,
    input  logic [DATA_W-1:0] input_data,
    input  logic              tm_halt,
    output logic              tape_we,
    output logic [ADDR_W-1:0] tape_addr,
    output logic [DATA_W-1:0] tape_wdata,
    output logic              tm_start,
    output logic              tm_step,
    output logic [1:0]        state,
    output logic [15:0]       step_count,
    output logic [ADDR_W:0]   load_len,
    output logic              compute_done,
    output logic              timeout
);

    localparam int unsigned DIV_W = $clog2(STEP_DIV);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    state_t             cur_state, state_d;
    logic               next_prev, done_prev;
    logic               rise_next, rise_done;
    logic [ADDR_W:0]    ptr, ptr_d;
    logic [DIV_W-1:0]   div, div_d;
    logic               we_d, start_d, step_d, cdone_d, tout_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  wdata_d;
    logic [15:0]        cnt_d, cnt_inc;
    logic [ADDR_W:0]    len_d;

    assign rise_next = next_in & ~next_prev;
    assign rise_done = done_in & ~done_prev;
    assign cnt_inc   = (step_count == 16'hFFFF) ? step_count : step_count + 16'd1;
    assign state     = cur_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state    <= ST_LOAD;
            next_prev    <= 1'b1;
            done_prev    <= 1'b1;
            ptr          <= '0;
            div          <= '0;
            tape_we      <= 1'b0;
            tape_addr    <= '0;
            tape_wdata   <= '0;
            tm_start     <= 1'b0;
            tm_step      <= 1'b0;
            step_count   <= '0;
            load_len     <= '0;
            compute_done <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            cur_state    <= state_d;
            next_prev    <= next_in;
            done_prev    <= done_in;
            ptr          <= ptr_d;
            div          <= div_d;
            tape_we      <= we_d;
            tape_addr    <= addr_d;
            tape_wdata   <= wdata_d;
            tm_start     <= start_d;
            tm_step      <= step_d;
            step_count   <= cnt_d;
            load_len     <= len_d;
            compute_done <= cdone_d;
            timeout      <= tout_d;
        end
    end

    always_comb begin
        state_d = cur_state;
        ptr_d   = ptr;
        div_d   = div;
        we_d    = 1'b0;
        addr_d  = tape_addr;
        wdata_d = tape_wdata;
        start_d = 1'b0;
        step_d  = 1'b0;
        cnt_d   = step_count;
        len_d   = load_len;
        cdone_d = compute_done;
        tout_d  = timeout;

        case (cur_state)
            ST_LOAD: begin
                if (rise_done) begin
                    len_d   = ptr;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    div_d   = '0;
                    ptr_d   = '0;
                    addr_d  = '0;
                    cdone_d = 1'b0;
                    tout_d  = 1'b0;
                    state_d = ST_RUN;
                end else if (rise_next && (ptr < (ADDR_W+1)'(TAPE_LEN))) begin
                    we_d    = 1'b1;
                    addr_d  = ptr[ADDR_W-1:0];
                    wdata_d = input_data;
                    ptr_d   = ptr + 1'b1;
                end
            end

            ST_RUN: begin
                addr_d = '0;
                // Priority: halt, then step budget, then stepping source.
                if (tm_halt) begin
                    cdone_d = 1'b1;
                    ptr_d   = '0;
                    state_d = ST_SHOW;
                end else if (step_count == 16'(MAX_STEPS)) begin
                    tout_d  = 1'b1;
                    ptr_d   = '0;
                    state_d = ST_SHOW;
`ifdef SINGLE_STEP_EN
                end else if (rise_done) begin
                    ptr_d   = '0;
                    state_d = ST_SHOW;
                end else if (rise_next) begin
                    step_d  = 1'b1;
                    cnt_d   = cnt_inc;
                end
`else
                end else if (div == DIV_W'(STEP_DIV - 1)) begin
                    div_d   = '0;
                    step_d  = 1'b1;
                    cnt_d   = cnt_inc;
                end else begin
                    div_d   = div + 1'b1;
                end
`endif
            end

            ST_SHOW: begin
                if (rise_done) begin
                    ptr_d   = '0;
                    addr_d  = '0;
                    cdone_d = 1'b0;
                    tout_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end else if (rise_next) begin
                    if (ptr == (ADDR_W+1)'(TAPE_LEN - 1))
                        ptr_d = '0;
                    else
                        ptr_d = ptr + 1'b1;
                    addr_d = ptr_d[ADDR_W-1:0];
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

endmodule

// File: doc/tm_run_controller.md
Name: tm_run_controller

Overview:
- Sequencer for the 128-cell Turing machine datapath. Owns the button-driven operating flow: tape loading, compute start, step pacing, halt/timeout detection, and result scroll-out.
- Sits between the synchronized Next/Done/data inputs and the machine core.
- Drives the tape write port, start/step strobes and status flags.

Parameters:
- DATA_W, 7, tape symbol width
- TAPE_LEN, 128, number of tape cells; ADDR_W = $clog2(TAPE_LEN)
- STEP_DIV, 4, clocks per machine step in RUN (>=2)
- MAX_STEPS, 4096, step budget before timeout (<=65535)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- next_in  in  1  synchronized Next button level
- done_in  in  1  synchronized Done button level
- input_data  in  DATA_W  synchronized symbol to load
- tm_halt  in  1  machine halted (level)
- tape_we  out  1  tape write strobe
- tape_addr  out  ADDR_W  tape address (load / display pointer)
- tape_wdata  out  DATA_W  tape write data
- tm_start  out  1  one-cycle start pulse
- tm_step  out  1  one-cycle step enable
- state  out  2  LOAD=0, RUN=1, SHOW=2
- step_count  out  16  steps issued since start
- load_len  out  ADDR_W+1  cells written in last LOAD
- compute_done  out  1  halted normally
- timeout  out  1  step budget exhausted

Behaviour:
- Reset (async, active-high) values:
  - state=LOAD; all strobes 0; tape_addr=0; tape_wdata=0; step_count=0; load_len=0; compute_done=0; timeout=0.
  - Edge-detect history registers cleared to 1, so a button held through reset produces no edge.
- Edge detect: rise_X = X_in & ~X_prev, with X_prev registered every cycle. All outputs are registered, so a strobe appears 1 cycle after the edge cycle.
- LOAD:
  - rise_next with ptr<TAPE_LEN: tape_we=1 for 1 cycle, tape_addr=ptr, tape_wdata=input_data; ptr increments afterwards.
  - Tape full (ptr==TAPE_LEN): further rise_next is ignored, with no write and no wrap.
  - rise_done: load_len<=ptr; tm_start=1 for 1 cycle; step_count<=0; divider<=0; next state RUN.
  - rise_next and rise_done in the same cycle: done wins, no write.
  - rise_done with ptr==0 is legal (empty tape).
- RUN:
  - tape_we=0 and tape_addr=0; buttons are ignored.
  - Divider counts 0..STEP_DIV-1. When it reaches STEP_DIV-1 and tm_halt=0, tm_step=1 for 1 cycle and step_count increments.
  - First step issues STEP_DIV cycles after tm_start.
  - tm_halt=1 sampled: next state SHOW, compute_done=1, no further steps.
  - step_count==MAX_STEPS and tm_halt=0: next state SHOW, timeout=1.
  - Halt in the same cycle as budget exhaustion: halt wins, timeout=0.
  - tm_halt high in the cycle after tm_start: zero steps, compute_done=1.
- SHOW:
  - tape_addr = display ptr, starting at 0.
  - rise_next: ptr increments, wrapping TAPE_LEN-1 -> 0.
  - rise_done: next state LOAD; ptr, compute_done, timeout and step_count cleared; load_len retained.
  - Simultaneous next and done: done wins.
- Reset mid-operation: any state returns to the reset values immediately; tape contents are not touched.
- step_count saturates at 16'hFFFF.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - In RUN, the divider is bypassed; each rise_next issues exactly one tm_step, registered 1 cycle later.
  - rise_done in RUN aborts to SHOW with compute_done=0 and timeout=0.
  - Halt and MAX_STEPS rules are unchanged.
- Undefined: free-running divider stepping as above; buttons are ignored in RUN.

Test Plan:
- Load 3 symbols: pulse next 3x with input_data=7'h11,7'h22,7'h33 -> tape_we at addr 0,1,2 with those data. Then done -> tm_start pulse, load_len=3, state=RUN.
- Fill tape: 130 next pulses -> exactly 128 writes (addr 0..127). Pulses 129 and 130 produce no tape_we.
- Step pacing with STEP_DIV=4: tm_halt held low, tm_halt raised after the 5th tm_step -> tm_step every 4 cycles, step_count=5, state=SHOW, compute_done=1, timeout=0.
- Timeout with MAX_STEPS=8: tm_halt never asserts -> exactly 8 tm_step pulses, then SHOW with timeout=1. Separately, halt coinciding with the 8th step -> compute_done=1, timeout=0.
- SHOW scroll: 129 next pulses -> tape_addr goes 1..127 then 0, then 1. A done pulse -> state=LOAD, flags cleared, load_len unchanged. Next and done in the same cycle -> LOAD only.
- Async reset asserted mid-RUN between clock edges -> outputs reach reset values without a clock edge. next_in held high across reset release -> no write.
